pipe_ctrl: RTL and testbench

//  Pipeline sequencer for the fetch/decode/exec front end. Watches the decode

---
 rtl/pipe_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - fetch/decode/exec pipeline stall, flush and bubble sequencer
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
    parameter int REG_W     = 6,
    parameter int LU_CYCLES = 1,
    parameter int FL_CYCLES = 1,
    parameter int PERF_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    input  logic [REG_W-1:0]  dec_rs1,
    input  logic [REG_W-1:0]  dec_rs2,
    input  logic              dec_use_rs1,
    input  logic              dec_use_rs2,
    input  logic              exec_valid,
    input  logic [REG_W-1:0]  exec_rd,
    input  logic              exec_mem_r,
    input  logic              exec_redirect,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              ftch_stall,
    output logic              dec_stall,
    output logic              exec_stall,
    output logic              ftch_flush,
    output logic              dec_flush,
    output logic              exec_bubble,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt
);

    typedef enum logic [1:0] {RUN, LU_STALL, FLUSH, MEM_WAIT} state_t;

    localparam int CNT_MAX = (LU_CYCLES > FL_CYCLES) ? LU_CYCLES : FL_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] LU_INIT = CNT_W'((LU_CYCLES > 1) ? LU_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] FL_INIT = CNT_W'((FL_CYCLES > 1) ? FL_CYCLES - 2 : 0);

    state_t           state_q, state_d;
    state_t           ret_q, ret_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           eff_state;
    logic             mem_wait;
    logic             lu_haz;

    assign mem_wait = mem_req & ~mem_ready;
    assign lu_haz   = dec_valid & exec_valid & exec_mem_r & (exec_rd != '0) &
                      ((dec_use_rs1 & (dec_rs1 == exec_rd)) |
                       (dec_use_rs2 & (dec_rs2 == exec_rd)));

    // While waiting on memory the saved state stands in for the current one,
    // so the cycle mem_ready arrives is evaluated as if no wait had occurred.
    assign eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            ret_q   <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        cnt_d       = cnt_q;
        ftch_stall  = 1'b0;
        dec_stall   = 1'b0;
        exec_stall  = 1'b0;
        ftch_flush  = 1'b0;
        dec_flush   = 1'b0;
        exec_bubble = 1'b0;

        if (mem_wait) begin
            ftch_stall = 1'b1;
            dec_stall  = 1'b1;
            exec_stall = 1'b1;
            state_d    = MEM_WAIT;
            ret_d      = eff_state;
        end else if (exec_redirect) begin
            ftch_flush  = 1'b1;
            dec_flush   = 1'b1;
            exec_bubble = 1'b1;
            if (FL_CYCLES > 1) begin
                state_d = FLUSH;
                cnt_d   = FL_INIT;
            end else begin
                state_d = RUN;
            end
        end else begin
            case (eff_state)
                LU_STALL: begin
                    ftch_stall  = 1'b1;
                    dec_stall   = 1'b1;
                    exec_bubble = 1'b1;
                    state_d     = (cnt_q == '0) ? RUN : LU_STALL;
                    cnt_d       = (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);
                end
                FLUSH: begin
                    ftch_flush  = 1'b1;
                    dec_flush   = 1'b1;
                    exec_bubble = 1'b1;
                    state_d     = (cnt_q == '0) ? RUN : FLUSH;
                    cnt_d       = (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);
                end
                default: begin
                    state_d = RUN;
                    if (lu_haz) begin
                        ftch_stall  = 1'b1;
                        dec_stall   = 1'b1;
                        exec_bubble = 1'b1;
                        if (LU_CYCLES > 1) begin
                            state_d = LU_STALL;
                            cnt_d   = LU_INIT;
                        end
                    end
                end
            endcase
        end

        // Reset holds the front end squashed regardless of state.
        if (rst) begin
            ftch_stall  = 1'b0;
            dec_stall   = 1'b0;
            exec_stall  = 1'b0;
            ftch_flush  = 1'b1;
            dec_flush   = 1'b1;
            exec_bubble = 1'b1;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] flush_cnt_q;
    logic              redir_acc;

    assign redir_acc = exec_redirect & ~mem_wait;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (ftch_stall)
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            if (redir_acc)
                flush_cnt_q <= flush_cnt_q + PERF_W'(1);
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed bench for pipe_ctrl with two parameterisations
module tb_pipe_ctrl;

    localparam logic [5:0] Z = 6'b000000;
    localparam logic [5:0] S = 6'b110001;
    localparam logic [5:0] F = 6'b000111;
    localparam logic [5:0] M = 6'b111000;
`ifdef PIPE_CTRL_PERF_EN
    localparam int PERF_ON = 1;
`else
    localparam int PERF_ON = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       dec_valid, dec_use_rs1, dec_use_rs2;
    logic [5:0] dec_rs1, dec_rs2, exec_rd;
    logic       exec_valid, exec_mem_r, exec_redirect, mem_req, mem_ready;

    logic        fs_a, ds_a, es_a, ff_a, df_a, eb_a;
    logic        fs_b, ds_b, es_b, ff_b, df_b, eb_b;
    logic [31:0] ps_a, pf_a;
    logic [3:0]  ps_b, pf_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.REG_W(6), .LU_CYCLES(1), .FL_CYCLES(1), .PERF_W(32)) u_a (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .exec_valid(exec_valid),
        .exec_rd(exec_rd), .exec_mem_r(exec_mem_r), .exec_redirect(exec_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready), .ftch_stall(fs_a), .dec_stall(ds_a),
        .exec_stall(es_a), .ftch_flush(ff_a), .dec_flush(df_a), .exec_bubble(eb_a),
        .perf_stall_cnt(ps_a), .perf_flush_cnt(pf_a)
    );

    pipe_ctrl #(.REG_W(6), .LU_CYCLES(3), .FL_CYCLES(2), .PERF_W(4)) u_b (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .exec_valid(exec_valid),
        .exec_rd(exec_rd), .exec_mem_r(exec_mem_r), .exec_redirect(exec_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready), .ftch_stall(fs_b), .dec_stall(ds_b),
        .exec_stall(es_b), .ftch_flush(ff_b), .dec_flush(df_b), .exec_bubble(eb_b),
        .perf_stall_cnt(ps_b), .perf_flush_cnt(pf_b)
    );

    task automatic idle();
        dec_valid = 0; dec_use_rs1 = 0; dec_use_rs2 = 0;
        dec_rs1 = 0; dec_rs2 = 0; exec_rd = 0;
        exec_valid = 0; exec_mem_r = 0; exec_redirect = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    task automatic hazard(input logic [5:0] rd);
        dec_valid = 1; dec_use_rs2 = 1; dec_rs2 = rd;
        exec_valid = 1; exec_mem_r = 1; exec_rd = rd;
    endtask

    // Outputs ordered {ftch_stall, dec_stall, exec_stall, ftch_flush, dec_flush, exec_bubble}
    task automatic cyc(input string tag, input logic [5:0] ea, input logic [5:0] eb);
        logic [5:0] oa, ob;
        @(negedge clk);
        oa = {fs_a, ds_a, es_a, ff_a, df_a, eb_a};
        ob = {fs_b, ds_b, es_b, ff_b, df_b, eb_b};
        n_cmp++;
        assert (oa === ea) else begin
            n_err++;
            $error("FAIL %s/a observed %b expected %b", tag, oa, ea);
        end
        n_cmp++;
        assert (ob === eb) else begin
            n_err++;
            $error("FAIL %s/b observed %b expected %b", tag, ob, eb);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        idle();
        rst = 1;
        cyc("rst0", F, F);
        cyc("rst1", F, F);
        rst = 0;
        cyc("idle", Z, Z);
        chk("perf_stall_rst", ps_a, 0);
        chk("perf_flush_rst", pf_a, 0);

        // load-use on rs2; b keeps bubbling for 3 cycles
        hazard(6'd5);
        cyc("lu1", S, S);
        idle();
        cyc("lu2", Z, S);
        cyc("lu3", Z, S);
        cyc("lu4", Z, Z);

        // register 0 and unused operand never hazard
        hazard(6'd0);
        cyc("lu_r0", Z, Z);
        hazard(6'd7);
        dec_use_rs2 = 0;
        cyc("lu_nouse", Z, Z);
        idle();

        // rs1 path, then redirect cancels b's pending stall
        hazard(6'd9);
        dec_use_rs2 = 0; dec_use_rs1 = 1; dec_rs1 = 6'd9; dec_rs2 = 6'd1;
        cyc("lu_rs1", S, S);
        idle();
        exec_redirect = 1;
        cyc("redir_in_lu", F, F);
        exec_redirect = 0;
        cyc("flush2", Z, F);
        cyc("after_flush", Z, Z);

        // redirect then load-use in flush window
        exec_redirect = 1;
        cyc("redir", F, F);
        exec_redirect = 0;
        hazard(6'd5);
        cyc("haz_in_flush", S, F);
        idle();
        cyc("post", Z, Z);

        // memory wait holds redirect, taken on mem_ready
        mem_req = 1; exec_redirect = 1;
        for (int i = 0; i < 4; i++) cyc("memwait", M, M);
        mem_ready = 1;
        cyc("mem_done", F, F);
        idle();
        cyc("mem_flush2", Z, F);
        cyc("mem_post", Z, Z);

        // memory wait inside LU_STALL preserves the remaining count
        hazard(6'd3);
        cyc("lu_pre_mw", S, S);
        idle();
        mem_req = 1;
        cyc("mw_in_lu", M, M);
        mem_ready = 1;
        cyc("mw_ret_lu", Z, S);
        idle();
        cyc("lu_last", Z, S);
        cyc("lu_end", Z, Z);

        // performance counters: load-use then memory-wait redirect
        rst = 1;
        cyc("rst2", F, F);
        rst = 0;
        hazard(6'd5);
        cyc("p_lu1", S, S);
        idle();
        cyc("p_lu2", Z, S);
        cyc("p_lu3", Z, S);
        mem_req = 1; exec_redirect = 1;
        for (int i = 0; i < 4; i++) cyc("p_mw", M, M);
        mem_ready = 1;
        cyc("p_done", F, F);
        idle();
        chk("perf_stall_a", ps_a, 32'(PERF_ON * 5));
        chk("perf_flush_a", pf_a, 32'(PERF_ON * 1));
        chk("perf_stall_b", {28'd0, ps_b}, 32'(PERF_ON * 7));
        chk("perf_flush_b", {28'd0, pf_b}, 32'(PERF_ON * 1));

        // 17 stall cycles wrap the 4-bit counter to 1
        rst = 1;
        cyc("rst3", F, F);
        rst = 0;
        mem_req = 1;
        for (int i = 0; i < 17; i++) cyc("p_wrap", M, M);
        idle();
        chk("perf_wrap_a", ps_a, 32'(PERF_ON * 17));
        chk("perf_wrap_b", {28'd0, ps_b}, 32'(PERF_ON * 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
